// File: rtl/qif_neuron_array.sv
// rtl/qif_neuron_array.sv - time-multiplexed quadratic integrate-and-fire neuron array
// One channel updated per accepted beat; registered result one cycle later.
module qif_neuron_array #(
  parameter int W       = 8,
  parameter int N_CH    = 4,
  parameter int CHW     = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int V_RESET = -20,
  parameter int V_TH    = 50,
  parameter int SH_V    = 3,
  parameter int SH_I    = 2,
  parameter int REFRAC  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_valid,
  input  logic [CHW-1:0] in_ch,
  input  logic [W-1:0]   I_syn,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic [W-1:0]   V_out,
  output logic           spike
);

  localparam int NW = 2 * W + 2;
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic signed [W-1:0]  C_VRST = W'(V_RESET);
  localparam logic signed [NW-1:0] C_VTH  = NW'(V_TH);
  localparam logic signed [NW-1:0] C_MAX  = NW'((2 ** (W - 1)) - 1);
  localparam logic signed [NW-1:0] C_MIN  = NW'(-(2 ** (W - 1)));
  localparam logic signed [NW-1:0] C_BV   = NW'((2 ** SH_V) - 1);
  localparam logic signed [NW-1:0] C_BI   = NW'((2 ** SH_I) - 1);
  localparam logic signed [NW-1:0] C_ZERO = '0;
  localparam logic [RW-1:0]        C_REF  = RW'(REFRAC);
  localparam logic [CHW:0]         C_NCH  = (CHW + 1)'(N_CH);

  logic signed [W-1:0] r_v   [N_CH];
  logic [RW-1:0]       r_ref [N_CH];
  logic                r_out_valid;
  logic [CHW-1:0]      r_out_ch;
  logic signed [W-1:0] r_v_out;
  logic                r_spike;

  logic                 w_accept;
  logic [CHW-1:0]       w_idx;
  logic signed [W-1:0]  w_v;
  logic [RW-1:0]        w_ref;
  logic signed [NW-1:0] w_vx, w_ix, w_vb, w_ib, w_q, w_i, w_prod, w_n, w_sat;
  logic                 w_fire;

  always_comb begin
    w_accept = in_valid & ~clr & ({1'b0, in_ch} < C_NCH);
    w_idx    = w_accept ? in_ch : '0;
    w_v      = r_v[w_idx];
    w_ref    = r_ref[w_idx];
    w_vx     = {{(NW - W){w_v[W-1]}}, w_v};
    w_ix     = {{(NW - W){I_syn[W-1]}}, I_syn};
    // Bias negatives before the arithmetic shift so division truncates toward zero
    w_vb     = w_vx + (w_vx[NW-1] ? C_BV : C_ZERO);
    w_ib     = w_ix + (w_ix[NW-1] ? C_BI : C_ZERO);
    w_q      = w_vb >>> SH_V;
    w_i      = w_ib >>> SH_I;
    w_prod   = w_q * w_q;
    w_n      = w_vx + w_prod + w_i;
    if (w_n > C_MAX)      w_sat = C_MAX;
    else if (w_n < C_MIN) w_sat = C_MIN;
    else                  w_sat = w_n;
    w_fire   = (w_sat >= C_VTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        r_v[k]   <= C_VRST;
        r_ref[k] <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_v_out     <= C_VRST;
      r_spike     <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < N_CH; k++) begin
        r_v[k]   <= C_VRST;
        r_ref[k] <= '0;
      end
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_ch <= in_ch;
        if (w_ref != '0) begin
          r_v[w_idx]   <= C_VRST;
          r_ref[w_idx] <= w_ref - RW'(1);
          r_v_out      <= C_VRST;
          r_spike      <= 1'b0;
        end else if (w_fire) begin
          r_v[w_idx]   <= C_VRST;
          r_ref[w_idx] <= C_REF;
          r_v_out      <= C_VRST;
          r_spike      <= 1'b1;
        end else begin
          r_v[w_idx]   <= w_sat[W-1:0];
          r_v_out      <= w_sat[W-1:0];
          r_spike      <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign V_out     = r_v_out;
  assign spike     = r_spike;

endmodule

// File: tb/tb_qif_neuron_array.sv
// tb/tb_qif_neuron_array.sv - bench for qif_neuron_array
// Directed table, hand sequences on a second instance, randomized run against a model.
module tb_qif_neuron_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clr0, vld0, ov0, spk0;
  logic [1:0] ch0, och0;
  logic [7:0] is0, vo0;
  logic       clr1, vld1, ov1, spk1;
  logic [1:0] ch1, och1;
  logic [7:0] is1, vo1;

  qif_neuron_array #(.W(8), .N_CH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .in_valid(vld0), .in_ch(ch0), .I_syn(is0),
    .out_valid(ov0), .out_ch(och0), .V_out(vo0), .spike(spk0)
  );

  qif_neuron_array #(.W(8), .N_CH(3), .V_TH(127)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .in_valid(vld1), .in_ch(ch1), .I_syn(is1),
    .out_valid(ov1), .out_ch(och1), .V_out(vo1), .spike(spk1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: neuron rules with plain integer arithmetic (int '/' truncates toward zero)
  int mv [2][4];
  int mr [2][4];
  int lch [2], lv [2], lspk [2], lval [2];
  int vth [2] = '{50, 127};
  int nch [2] = '{4, 3};

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        mv[d][c] = -20;
        mr[d][c] = 0;
      end
      lch[d] = 0; lv[d] = -20; lspk[d] = 0; lval[d] = 0;
    end
  endfunction

  function automatic void model_step(input int d, input bit v, input bit c, input int ch, input int is);
    int n;
    lval[d] = 0;
    if (c) begin
      for (int k = 0; k < 4; k++) begin
        mv[d][k] = -20;
        mr[d][k] = 0;
      end
    end else if (v && ch < nch[d]) begin
      lval[d] = 1;
      lch[d] = ch;
      if (mr[d][ch] > 0) begin
        mr[d][ch]--;
        mv[d][ch] = -20;
        lv[d] = -20; lspk[d] = 0;
      end else begin
        n = mv[d][ch] + (mv[d][ch] / 8) * (mv[d][ch] / 8) + is / 4;
        if (n > 127) n = 127;
        if (n < -128) n = -128;
        if (n >= vth[d]) begin
          mv[d][ch] = -20; mr[d][ch] = 2;
          lv[d] = -20; lspk[d] = 1;
        end else begin
          mv[d][ch] = n;
          lv[d] = n; lspk[d] = 0;
        end
      end
    end
  endfunction

  typedef struct {
    bit vld; bit clr; int ch; int isyn;
    bit ev; int ech; int evo; bit espk;
  } vec_t;

  vec_t tbl[$];

  task automatic beat1(input string nm, input bit v, input bit c, input int ch, input int is,
                       input bit ev, input int ech, input int evo, input bit es);
    vld1 = v; clr1 = c; ch1 = 2'(ch); is1 = 8'(is);
    tick();
    check({nm, "_valid"}, int'(ov1), int'(ev));
    check({nm, "_ch"}, int'(och1), ech);
    check({nm, "_v"}, int'($signed(vo1)), evo);
    check({nm, "_spike"}, int'(spk1), int'(es));
  endtask

  initial begin
    int s;
    bit rv, rc;
    int rch;
    rst_n = 1'b0;
    clr0 = 0; vld0 = 1; ch0 = 0; is0 = 8'd40;
    clr1 = 0; vld1 = 1; ch1 = 0; is1 = 8'd40;
    tick(); tick();
    check("rst_valid0", int'(ov0), 0);
    check("rst_v0", int'($signed(vo0)), -20);
    check("rst_spike0", int'(spk0), 0);
    check("rst_valid1", int'(ov1), 0);
    vld0 = 0; vld1 = 0;
    rst_n = 1'b1;
    tick();

    tbl.push_back('{1, 0, 0, 40,   1, 0, -6, 0});
    tbl.push_back('{1, 0, 0, 40,   1, 0, 4, 0});
    tbl.push_back('{1, 0, 1, 0,    1, 1, -16, 0});
    tbl.push_back('{1, 0, 0, 40,   1, 0, 14, 0});
    tbl.push_back('{1, 0, 2, 127,  1, 2, 15, 0});
    tbl.push_back('{1, 0, 2, 127,  1, 2, 47, 0});
    tbl.push_back('{1, 0, 2, 127,  1, 2, -20, 1});
    tbl.push_back('{1, 0, 2, 127,  1, 2, -20, 0});
    tbl.push_back('{1, 0, 2, 127,  1, 2, -20, 0});
    tbl.push_back('{0, 0, 3, 5,    0, 2, -20, 0});
    tbl.push_back('{1, 0, 2, 127,  1, 2, 15, 0});
    tbl.push_back('{1, 0, 3, -128, 1, 3, -48, 0});
    tbl.push_back('{1, 0, 3, -128, 1, 3, -44, 0});
    tbl.push_back('{1, 1, 0, 40,   0, 3, -44, 0});
    tbl.push_back('{1, 0, 3, 0,    1, 3, -16, 0});
    tbl.push_back('{1, 0, 2, 0,    1, 2, -16, 0});
    for (int i = 0; i < tbl.size(); i++) begin
      vld0 = tbl[i].vld; clr0 = tbl[i].clr; ch0 = 2'(tbl[i].ch); is0 = 8'(tbl[i].isyn);
      tick();
      check($sformatf("vec%0d_valid", i), int'(ov0), int'(tbl[i].ev));
      check($sformatf("vec%0d_ch", i), int'(och0), tbl[i].ech);
      check($sformatf("vec%0d_v", i), int'($signed(vo0)), tbl[i].evo);
      check($sformatf("vec%0d_spike", i), int'(spk0), int'(tbl[i].espk));
    end
    vld0 = 0; clr0 = 0;

    beat1("sat_a",    1, 0, 0, 127, 1, 0, 15, 0);
    beat1("sat_b",    1, 0, 0, 127, 1, 0, 47, 0);
    beat1("illegal",  1, 0, 3, 127, 0, 0, 47, 0);
    beat1("sat_c",    1, 0, 0, 127, 1, 0, 103, 0);
    beat1("sat_fire", 1, 0, 0, 127, 1, 0, -20, 1);
    beat1("sat_ref",  1, 0, 0, 127, 1, 0, -20, 0);
    beat1("clr",      1, 1, 0, 127, 0, 0, -20, 0);
    beat1("clr_ch0",  1, 0, 0, 0,   1, 0, -16, 0);
    beat1("clr_ch1",  1, 0, 1, 0,   1, 1, -16, 0);
    beat1("clr_ch2",  1, 0, 2, 0,   1, 2, -16, 0);
    vld1 = 0; clr1 = 0;

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        vld0 = 1; vld1 = 1; clr0 = 0; clr1 = 0; ch0 = 0; ch1 = 0; is0 = 8'd100; is1 = 8'd100;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid0", int'(ov0), 0);
        check("midrst_v0", int'($signed(vo0)), -20);
        check("midrst_valid1", int'(ov1), 0);
        check("midrst_ch1", int'(och1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        vld0 = 0; vld1 = 0;
      end else begin
        rv  = ($urandom_range(0, 3) != 0);
        rc  = ($urandom_range(0, 24) == 0);
        rch = $urandom_range(0, 3);
        s   = $urandom_range(0, 255);
        vld0 = rv; vld1 = rv; clr0 = rc; clr1 = rc;
        ch0 = 2'(rch); ch1 = 2'(rch); is0 = 8'(s); is1 = 8'(s);
        if (s > 127) s = s - 256;
        model_step(0, rv, rc, rch, s);
        model_step(1, rv, rc, rch, s);
        tick();
        check($sformatf("rnd%0d_valid0", i), int'(ov0), lval[0]);
        check($sformatf("rnd%0d_ch0", i), int'(och0), lch[0]);
        check($sformatf("rnd%0d_v0", i), int'($signed(vo0)), lv[0]);
        check($sformatf("rnd%0d_spike0", i), int'(spk0), lspk[0]);
        check($sformatf("rnd%0d_valid1", i), int'(ov1), lval[1]);
        check($sformatf("rnd%0d_ch1", i), int'(och1), lch[1]);
        check($sformatf("rnd%0d_v1", i), int'($signed(vo1)), lv[1]);
        check($sformatf("rnd%0d_spike1", i), int'(spk1), lspk[1]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
